// File: rtl/mux_n_arb_pkg.sv
// Shared select-mode constants and a one-hot check for the one-hot select blocks.
// Pure declarations: no latency and no flow control.
package mux_n_arb_pkg;

  localparam logic SEL_MODE_RR     = 1'b0;
  localparam logic SEL_MODE_ONEHOT = 1'b1;

  // Callers zero-extend narrower select vectors to this width.
  localparam int ONEHOT_MAX_W = 64;

  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/mux_n_arb_rr_arbiter.sv
// Combinational rotate-priority arbiter: lowest request above the one-hot pointer wins, wrapping.
// Zero latency; no backpressure of its own (grant is zero when nothing requests).
module rr_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] pointer,
  output logic [CHANNELS-1:0] grant
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [IDXW-1:0] ptr_idx;
  logic            found;

  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pointer[i]) ptr_idx = i[IDXW-1:0];
    end

    grant = '0;
    found = 1'b0;
    // Offset k=1 is the channel just after the last winner; k=CHANNELS is the last winner itself.
    for (int k = 1; k <= CHANNELS; k++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && req[i] && (((int'(ptr_idx) + k) % CHANNELS) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_arb.sv
// N-channel valid/ready mux, round-robin or external one-hot select, into a single-entry output register.
// Latency 1 cycle; full throughput; in_ready is zero while the held word is stalled by out_ready=0.
module mux_n_arb
  import mux_n_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 1,
  parameter int CHANNELS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS*BUS_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  input  logic                          sel_mode,
  input  logic [CHANNELS-1:0]           selector,
  output logic [BUS_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS-1:0]           out_chan,
  output logic                          sel_err
);

  localparam logic [CHANNELS-1:0] PTR_RST = {1'b1, {(CHANNELS-1){1'b0}}};

  logic [CHANNELS-1:0]     pointer;
  logic [CHANNELS-1:0]     rr_grant;
  logic [CHANNELS-1:0]     grant;
  logic [ONEHOT_MAX_W-1:0] sel_ext;
  logic                    sel_legal;
  logic                    load_en;
  logic                    xfer;
  logic                    sel_err_nxt;
  logic [BUS_WIDTH-1:0]    mux_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .req     (in_valid),
    .pointer (pointer),
    .grant   (rr_grant)
  );

  always_comb begin
    sel_ext                 = '0;
    sel_ext[CHANNELS-1:0]   = selector;
    sel_legal               = is_onehot(sel_ext);
    load_en                 = !out_valid || out_ready;

    if (sel_mode == SEL_MODE_ONEHOT) grant = sel_legal ? (selector & in_valid) : '0;
    else                             grant = rr_grant;

    xfer        = load_en && (grant != '0);
    sel_err_nxt = (sel_mode == SEL_MODE_ONEHOT) && !sel_legal && load_en;

    mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) mux_data = mux_data | in_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // rst_n gates in_ready so upstream sees acceptance drop as soon as reset asserts.
  assign in_ready = grant & {CHANNELS{load_en & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      sel_err   <= 1'b0;
      pointer   <= PTR_RST;
    end else begin
      sel_err <= sel_err_nxt;
      if (xfer) begin
        out_data  <= mux_data;
        out_chan  <= grant;
        out_valid <= 1'b1;
        pointer   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_arb.sv
// Randomized bench for mux_n_arb (4 x 8-bit) against a behavioural model, plus directed literal checks.
module tb_mux_n_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        sel_mode;
  logic [3:0]  selector;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_chan;
  logic        sel_err;

  int total = 0;
  int bad   = 0;
  logic run_chk = 1'b0;

  always #5 clk = ~clk;

  mux_n_arb #(.BUS_WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_mode  (sel_mode),
    .selector  (selector),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .sel_err   (sel_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: last winner index, output register contents, error flag.
  int         mptr;
  int         g;
  int         c;
  logic       mv;
  logic       merr;
  logic       load;
  logic [7:0] md;
  logic [3:0] mc;
  logic [3:0] exp_ir;

  initial forever begin
    @(negedge clk);
    if (run_chk) begin
      if (!rst_n) begin
        mptr = 3; mv = 1'b0; md = 8'h00; mc = 4'h0; merr = 1'b0;
      end
      load = !mv || out_ready;
      g = -1;
      if (!sel_mode) begin
        for (int k = 1; k <= 4; k++) begin
          c = (mptr + k) % 4;
          if (g < 0 && in_valid[c]) g = c;
        end
      end else if ($countones(selector) == 1) begin
        for (int j = 0; j < 4; j++) begin
          if (selector[j] && in_valid[j]) g = j;
        end
      end
      exp_ir = 4'h0;
      if (rst_n && load && g >= 0) exp_ir[g] = 1'b1;

      chk("m_in_ready",  32'(in_ready),  32'(exp_ir));
      chk("m_out_valid", 32'(out_valid), 32'(mv));
      chk("m_out_data",  32'(out_data),  32'(md));
      chk("m_out_chan",  32'(out_chan),  32'(mc));
      chk("m_sel_err",   32'(sel_err),   32'(merr));

      if (rst_n) begin
        merr = sel_mode && ($countones(selector) != 1) && load;
        if (load && g >= 0) begin
          md = in_data[g*8 +: 8];
          mc = 4'h0;
          mc[g] = 1'b1;
          mv = 1'b1;
          mptr = g;
        end else if (out_ready) begin
          mv = 1'b0;
        end
      end
    end
  end

  logic [7:0] dseq [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
  logic [3:0] cseq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst_n     = 1'b0;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid  = 4'hf;
    sel_mode  = 1'b0;
    selector  = 4'h0;
    out_ready = 1'b1;
    run_chk   = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_chan",  32'(out_chan),  32'h0);
    chk("rst_sel_err",   32'(sel_err),   32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    cyc();
    rst_n = 1'b1;

    // Fairness with all channels valid.
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fair_data",  32'(out_data),  32'(dseq[i]));
      chk("fair_chan",  32'(out_chan),  32'(cseq[i]));
      chk("fair_valid", 32'(out_valid), 32'h1);
    end

    // Park pointer on ch0, then alternate between ch2 and ch0.
    cyc(); in_valid = 4'b0001;
    cyc(); in_valid = 4'b0101;
    @(negedge clk); chk("alt_ir0", 32'(in_ready), 32'b0100);
    cyc();
    @(negedge clk); chk("alt_ir1", 32'(in_ready), 32'b0001); chk("alt_chan1", 32'(out_chan), 32'b0100);
    cyc(); in_data[23:16] = 8'h55;
    @(negedge clk); chk("alt_ir2", 32'(in_ready), 32'b0100); chk("alt_chan2", 32'(out_chan), 32'b0001);
    cyc(); out_ready = 1'b0; in_valid = 4'hf;

    // Stall: 0x55 must hold and nothing accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_data",  32'(out_data),  32'h55);
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_ir",    32'(in_ready),  32'h0);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("unstall_ir", 32'(in_ready), 32'b1000);
    cyc();
    @(negedge clk);
    chk("unstall_data",  32'(out_data),  32'h43);
    chk("unstall_chan",  32'(out_chan),  32'b1000);
    chk("unstall_valid", 32'(out_valid), 32'h1);

    // External one-hot selector, then illegal selectors.
    cyc(); sel_mode = 1'b1; selector = 4'b0100;
    @(negedge clk); chk("oh_ir0", 32'(in_ready), 32'b0100);
    cyc();
    @(negedge clk); chk("oh_chan", 32'(out_chan), 32'b0100); chk("oh_ir1", 32'(in_ready), 32'b0100);
    cyc(); selector = 4'b0110;
    @(negedge clk); chk("bad_ir", 32'(in_ready), 32'h0); chk("bad_valid_pre", 32'(out_valid), 32'h1);
    cyc(); selector = 4'b0000; in_valid = 4'h0;
    @(negedge clk); chk("bad_err", 32'(sel_err), 32'h1); chk("bad_drain", 32'(out_valid), 32'h0);
    cyc(); selector = 4'b0010; in_valid = 4'hf;
    @(negedge clk); chk("zero_sel_err", 32'(sel_err), 32'h1); chk("oh1_ir", 32'(in_ready), 32'b0010);
    cyc(); sel_mode = 1'b0;
    @(negedge clk);
    chk("switch_chan", 32'(out_chan), 32'b0010);
    chk("switch_err",  32'(sel_err),  32'h0);
    chk("switch_ir",   32'(in_ready), 32'b0100);

    // Asynchronous reset mid-stream.
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data",  32'(out_data),  32'h0);
    chk("arst_ir",    32'(in_ready),  32'h0);
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk("post_rst_ir", 32'(in_ready), 32'b0001);
    cyc();
    @(negedge clk); chk("post_rst_chan", 32'(out_chan), 32'b0001); chk("post_rst_data", 32'(out_data), 32'h10);

    // Randomized traffic, occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n     = ($urandom_range(0, 199) != 0);
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      sel_mode  = ($urandom_range(0, 3) == 0);
      selector  = ($urandom_range(0, 1) != 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
